// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-stage types: FSM encoding, fetch-entry layout and constants.
// Fetch entries carry {pc, instr, misaligned}, 65 bits wide.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ENTRY_W = PC_W + INSTR_W + 1;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               misaligned;
  } fetch_entry_t;

  function automatic fetch_entry_t make_entry(input logic [PC_W-1:0] pc,
                                              input logic [INSTR_W-1:0] instr,
                                              input logic misaligned);
    fetch_entry_t e;
    e.pc         = pc;
    e.instr      = instr;
    e.misaligned = misaligned;
    return e;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// Small FIFO between fetch and decode: push visible at head the next cycle, flush wins over push/pop.
// Backpressure: head held while pop_rdy is low; producer must respect full (push+pop when full is allowed).
module instruction_fetch_unit_fetch_buffer
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = ENTRY_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  output logic         pop_vld,
  input  logic         pop_rdy,
  output logic [W-1:0] pop_dat,
  output logic         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_vld = (count_q != '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_dat = mem_q[rd_ptr_q];
  assign push    = push_vld && !flush;
  assign pop     = pop_vld && pop_rdy && !flush;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Issue gating upstream keeps a push into a full buffer impossible unless the head leaves too.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(push && full && !pop));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, single-outstanding imem requests, redirect flush; resp at N -> if_valid at N+1.
// Backpressure: requests stop while the fetch buffer is full; decode stalls via if_ready.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int          BUF_DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] next_pc,
  input  logic        redirect,
  output logic [31:0] pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_misaligned
);

  fetch_state_e       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               aligned;
  logic               req_fire;
  logic               buf_flush;
  logic               buf_push_vld;
  fetch_entry_t       buf_push_dat;
  logic               buf_full;
  logic [ENTRY_W-1:0] buf_head_dat;
  fetch_entry_t       head;

  assign aligned        = (pc_q[1:0] == 2'b00);
  assign imem_req_valid = (state_q == ST_ISSUE) && aligned && !buf_full;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign buf_flush      = redirect && (state_q != ST_BOOT);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    buf_push_vld = 1'b0;
    buf_push_dat = make_entry(pc_q, imem_resp_data, 1'b0);
    unique case (state_q)
      ST_BOOT: state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (redirect) begin
          pc_d = next_pc;
          if (req_fire) state_d = ST_DRAIN;
        end else if (!aligned) begin
          // The fault entry stands in for the instruction; pc waits for the trap redirect.
          buf_push_vld = !buf_full;
          buf_push_dat = make_entry(pc_q, NOP_INSTR, 1'b1);
        end else if (req_fire) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          pc_d    = next_pc;
          state_d = imem_resp_valid ? ST_ISSUE : ST_DRAIN;
        end else if (imem_resp_valid) begin
          buf_push_vld = 1'b1;
          pc_d         = next_pc;
          state_d      = ST_ISSUE;
        end
      end
      ST_DRAIN: begin
        if (redirect) pc_d = next_pc;
        // Only one request is ever outstanding, so the stale response ends the drain.
        if (imem_resp_valid) state_d = ST_ISSUE;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  instruction_fetch_unit_fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .W     (ENTRY_W)
  ) u_fetch_buffer (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (buf_flush),
    .push_vld (buf_push_vld),
    .push_dat (buf_push_dat),
    .pop_vld  (if_valid),
    .pop_rdy  (if_ready),
    .pop_dat  (buf_head_dat),
    .full     (buf_full)
  );

  assign head          = fetch_entry_t'(buf_head_dat);
  assign pc            = pc_q;
  assign imem_addr     = pc_q;
  assign if_pc         = head.pc;
  assign if_instr      = head.instr;
  assign if_misaligned = head.misaligned;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: PC-controller and imem models plus a scoreboard of expected fetches.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] next_pc;
  logic        redirect;
  logic [31:0] redirect_tgt;
  logic [31:0] pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_misaligned;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          sb_pops = 0;
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_raddr = '0;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .next_pc         (next_pc),
    .redirect        (redirect),
    .pc              (pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_pc           (if_pc),
    .if_instr        (if_instr),
    .if_misaligned   (if_misaligned)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // PC controller: sequential pc+4 unless the bench forces a redirect target.
  assign next_pc = redirect ? redirect_tgt : pc + 32'd4;

  // Memory with configurable latency; shares reset so in-flight responses vanish.
  always @(posedge clk) begin
    if (!reset_n) begin
      mem_cnt <= 0;
    end else begin
      if (mem_cnt != 0) mem_cnt <= mem_cnt - 1;
      if (imem_req_valid && imem_req_ready) begin
        mem_cnt   <= mem_lat;
        mem_raddr <= imem_addr;
      end
    end
  end
  assign imem_resp_valid = (mem_cnt == 1);
  assign imem_resp_data  = imem_resp_valid ? mem_word(mem_raddr) : 32'hDEAD_BEEF;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc    = start + 32'(4 * i);
      e.instr = mem_word(e.pc);
      e.mis   = 1'b0;
      exp_q.push_back(e);
    end
  endtask

  // One clock: score any head consumed at the coming edge, return 1 time unit after it.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (if_valid && if_ready) begin
      check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("if_pc", if_pc, e.pc);
        check_eq("if_instr", if_instr, e.instr);
        check_eq("if_misaligned", 32'(if_misaligned), 32'(e.mis));
      end
      sb_pops++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pops(input int n, input int budget);
    int target;
    int b;
    target = sb_pops + n;
    b = 0;
    while (sb_pops < target && b < budget) begin
      tick();
      b++;
    end
    if_ready = 1'b0;
    check_eq("pops_done", 32'(sb_pops), 32'(target));
    check_eq("sb_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_req(input int budget);
    int b;
    b = 0;
    while (!imem_req_valid && b < budget) begin
      tick();
      b++;
    end
    check_eq("req_seen", 32'(imem_req_valid), 32'd1);
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    redirect       = 1'b0;
    redirect_tgt   = '0;
    imem_req_ready = 1'b1;
    if_ready       = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int hi;
    int b;
    reset_n        = 1'b0;
    redirect       = 1'b0;
    redirect_tgt   = '0;
    imem_req_ready = 1'b1;
    if_ready       = 1'b0;

    // 1: reset state, boot cycle, sequential stream with 1-cycle memory
    mem_lat = 1;
    do_reset();
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_if_valid", 32'(if_valid), 32'd0);
    check_eq("rst_if_pc", if_pc, 32'h0);
    check_eq("rst_if_instr", if_instr, 32'h0);
    check_eq("rst_if_mis", 32'(if_misaligned), 32'd0);
    tick();
    check_eq("t1_first_req", 32'(imem_req_valid), 32'd1);
    check_eq("t1_first_addr", imem_addr, 32'h0);
    push_seq(32'h0, 3);
    if_ready = 1'b1;
    wait_pops(3, 40);

    // 2: decode stalled -> buffer fills to two, requests stop, then drains in order
    do_reset();
    hi = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (i >= 6 && imem_req_valid) hi++;
    end
    check_eq("t2_req_while_full", 32'(hi), 32'd0);
    check_eq("t2_if_valid", 32'(if_valid), 32'd1);
    check_eq("t2_head_pc", if_pc, 32'h0);
    push_seq(32'h0, 3);
    if_ready = 1'b1;
    wait_pops(3, 40);

    // 3: redirect during a slow fetch -> stale response drained
    do_reset();
    mem_lat = 3;
    push_seq(32'h100, 2);
    if_ready = 1'b1;
    wait_req(10);
    tick();
    redirect     = 1'b1;
    redirect_tgt = 32'h100;
    tick();
    redirect = 1'b0;
    check_eq("t3_pc", pc, 32'h100);
    check_eq("t3_if_valid", 32'(if_valid), 32'd0);
    check_eq("t3_drain_req", 32'(imem_req_valid), 32'd0);
    tick();
    check_eq("t3_drain_req2", 32'(imem_req_valid), 32'd0);
    wait_pops(2, 60);

    // 4: redirect in the same cycle as the response -> dropped, new request next cycle
    do_reset();
    mem_lat = 1;
    push_seq(32'h300, 2);
    if_ready = 1'b1;
    wait_req(10);
    tick();
    redirect     = 1'b1;
    redirect_tgt = 32'h300;
    tick();
    redirect = 1'b0;
    check_eq("t4_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("t4_req_addr", imem_addr, 32'h300);
    check_eq("t4_if_valid", 32'(if_valid), 32'd0);
    wait_pops(2, 40);

    // 5: misaligned target -> fault entry, trap redirect resumes fetch
    do_reset();
    imem_req_ready = 1'b0;
    tick();
    redirect     = 1'b1;
    redirect_tgt = 32'h102;
    tick();
    redirect       = 1'b0;
    imem_req_ready = 1'b1;
    check_eq("t5_pc", pc, 32'h102);
    check_eq("t5_no_req", 32'(imem_req_valid), 32'd0);
    tick();
    check_eq("t5_if_valid", 32'(if_valid), 32'd1);
    check_eq("t5_if_pc", if_pc, 32'h102);
    check_eq("t5_if_instr", if_instr, NOP);
    check_eq("t5_if_mis", 32'(if_misaligned), 32'd1);
    check_eq("t5_no_req2", 32'(imem_req_valid), 32'd0);
    redirect     = 1'b1;
    redirect_tgt = 32'h200;
    tick();
    redirect = 1'b0;
    check_eq("t5_flushed", 32'(if_valid), 32'd0);
    check_eq("t5_trap_req", 32'(imem_req_valid), 32'd1);
    check_eq("t5_trap_addr", imem_addr, 32'h200);
    push_seq(32'h200, 2);
    if_ready = 1'b1;
    wait_pops(2, 40);

    // 6: reset while waiting with a buffered entry
    do_reset();
    mem_lat = 3;
    b = 0;
    while (!(if_valid && imem_req_valid) && b < 40) begin
      tick();
      b++;
    end
    check_eq("t6_setup", 32'(if_valid && imem_req_valid), 32'd1);
    tick();
    reset_n = 1'b0;
    tick();
    check_eq("t6_if_valid", 32'(if_valid), 32'd0);
    check_eq("t6_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("t6_pc", pc, 32'h0);
    check_eq("t6_if_pc", if_pc, 32'h0);
    reset_n = 1'b1;
    mem_lat = 1;
    push_seq(32'h0, 2);
    if_ready = 1'b1;
    wait_pops(2, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
